// File: rtl/uart_buffered.sv
// uart_buffered: UART with TX/RX FIFOs, shared 16x baud tick, oversampled receive.
// Define UART_BUFFERED_PARITY_EN to add an even-parity bit to every frame.
module uart_buffered #(
  parameter int freq_hz = 100000000,
  parameter int baud = 115200,
  parameter int data_bits = 8,
  parameter int stop_bits = 1,
  parameter int tx_depth = 16,
  parameter int rx_depth = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 uart_rxd,
  output logic                 uart_txd,
  input  logic [data_bits-1:0] tx_data,
  input  logic                 tx_wr,
  output logic                 tx_busy,
  output logic                 tx_idle,
  output logic [data_bits-1:0] rx_data,
  output logic                 rx_avail,
  input  logic                 rx_ack,
  output logic                 rx_error,
  output logic                 rx_overflow
);
  localparam int div_raw = freq_hz / (baud * 16);
  localparam int div = div_raw < 1 ? 1 : div_raw;
  localparam int cw = $clog2(div + 1);
  localparam int ta = $clog2(tx_depth);
  localparam int ra = $clog2(rx_depth);
  typedef enum logic [2:0] {
    IDLE, START, DATA,
`ifdef UART_BUFFERED_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
  logic [cw-1:0] bcnt;
  logic tick;
  assign tick = bcnt == cw'(div - 1);
  always_ff @(posedge clk) bcnt <= (reset || tick) ? '0 : bcnt + 1'b1;
  logic [data_bits-1:0] tx_mem [tx_depth];
  logic [ta:0] tx_wp, tx_rp;
  logic tx_empty, tx_pop, tx_end;
  state_t ts, ts_n;
  logic [3:0] tt, tbit;
  logic [data_bits-1:0] tsh;
`ifdef UART_BUFFERED_PARITY_EN
  logic tpar;
  always_ff @(posedge clk) if (tx_pop) tpar <= ^tx_mem[tx_rp[ta-1:0]];
`endif
  assign tx_empty = tx_wp == tx_rp;
  assign tx_busy = tx_wp[ta] != tx_rp[ta] && tx_wp[ta-1:0] == tx_rp[ta-1:0];
  assign tx_idle = ts == IDLE && tx_empty;
  assign tx_end = tick && tt == 4'd15;
  always_ff @(posedge clk) begin
    if (tx_wr && !tx_busy) tx_mem[tx_wp[ta-1:0]] <= tx_data;
    if (reset) begin
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      if (tx_wr && !tx_busy) tx_wp <= tx_wp + 1'b1;
      if (tx_pop) tx_rp <= tx_rp + 1'b1;
    end
  end
  always_comb begin
    ts_n = ts;
    tx_pop = 1'b0;
    uart_txd = 1'b1;
    case (ts)
      IDLE: if (tick && !tx_empty) begin
        ts_n = START;
        tx_pop = 1'b1;
      end
      START: begin
        uart_txd = 1'b0;
        if (tx_end) ts_n = DATA;
      end
      DATA: begin
        uart_txd = tsh[0];
`ifdef UART_BUFFERED_PARITY_EN
        if (tx_end && tbit == 4'(data_bits - 1)) ts_n = PARITY;
      end
      PARITY: begin
        uart_txd = tpar;
        if (tx_end) ts_n = STOP;
`else
        if (tx_end && tbit == 4'(data_bits - 1)) ts_n = STOP;
`endif
      end
      STOP: if (tx_end && tbit == 4'(stop_bits - 1)) begin
        ts_n = tx_empty ? IDLE : START;
        tx_pop = !tx_empty;
      end
      default: ts_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ts <= IDLE;
      tt <= '0;
      tbit <= '0;
    end else begin
      ts <= ts_n;
      tt <= ts_n != ts ? '0 : (ts != IDLE && tick) ? tt + 1'b1 : tt;
      tbit <= ts_n != ts ? '0 : tx_end ? tbit + 1'b1 : tbit;
    end
    if (tx_pop) tsh <= tx_mem[tx_rp[ta-1:0]];
    else if (ts == DATA && tx_end) tsh <= tsh >> 1;
  end
  logic [1:0] sync;
  logic rxs, rsamp, rperr, rx_push, rx_full, rx_pop, rx_wr;
  state_t rs, rs_n;
  logic [3:0] rt, rbit;
  logic [data_bits-1:0] rsh;
  logic [data_bits-1:0] rx_mem [rx_depth];
  logic [ra:0] rx_wp, rx_rp;
  assign rxs = sync[1];
  // start bit is checked at its middle; every later bit one full bit period on
  assign rsamp = tick && rt == (rs == START ? 4'd7 : 4'd15);
  always_ff @(posedge clk) sync <= reset ? 2'b11 : {sync[0], uart_rxd};
  always_comb begin
    rs_n = rs;
    rx_push = 1'b0;
    rx_error = 1'b0;
    case (rs)
      IDLE: if (tick && !rxs) rs_n = START;
      START: if (rsamp) rs_n = rxs ? IDLE : DATA;
`ifdef UART_BUFFERED_PARITY_EN
      DATA: if (rsamp && rbit == 4'(data_bits - 1)) rs_n = PARITY;
      PARITY: if (rsamp) rs_n = STOP;
`else
      DATA: if (rsamp && rbit == 4'(data_bits - 1)) rs_n = STOP;
`endif
      STOP: if (rsamp) begin
        rs_n = IDLE;
        rx_push = rxs && !rperr;
        rx_error = !(rxs && !rperr);
      end
      default: rs_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rs <= IDLE;
      rt <= '0;
      rbit <= '0;
    end else begin
      rs <= rs_n;
      rt <= rs_n != rs ? '0 : (rs != IDLE && tick) ? rt + 1'b1 : rt;
      rbit <= rs_n != rs ? '0 : rsamp ? rbit + 1'b1 : rbit;
    end
    if (rs == DATA && rsamp) rsh <= {rxs, rsh[data_bits-1:1]};
  end
`ifdef UART_BUFFERED_PARITY_EN
  always_ff @(posedge clk)
    if (reset) rperr <= 1'b0;
    else if (rs == PARITY && rsamp) rperr <= rxs ^ (^rsh);
`else
  assign rperr = 1'b0;
`endif
  assign rx_avail = rx_wp != rx_rp;
  assign rx_full = rx_wp[ra] != rx_rp[ra] && rx_wp[ra-1:0] == rx_rp[ra-1:0];
  assign rx_pop = rx_ack && rx_avail;
  assign rx_wr = rx_push && (!rx_full || rx_pop);
  assign rx_overflow = rx_push && !rx_wr;
  assign rx_data = rx_avail ? rx_mem[rx_rp[ra-1:0]] : '0;
  always_ff @(posedge clk) begin
    if (rx_wr) rx_mem[rx_wp[ra-1:0]] <= rsh;
    if (reset) begin
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (rx_wr) rx_wp <= rx_wp + 1'b1;
      if (rx_pop) rx_rp <= rx_rp + 1'b1;
    end
  end
endmodule

// File: doc/uart_buffered.md
# uart_buffered

Buffered, parametrised UART for the SoC peripheral bus and for use as the testbench communication partner. It provides a configurable word format (5–9 data bits, 1 or 2 stop bits) and 16× oversampled reception, with TX and RX FIFOs between the transmit/receive shifters and the user side. Its user-side signals follow the existing `uart` handshake (`tx_wr`/`tx_busy`, `rx_avail`/`rx_ack`/`rx_error`), so it drops in where `uart` is instantiated today.

## Interface
Parameters:
- freq_hz, 100000000, clock frequency in Hz
- baud, 115200, line bit rate
- data_bits, 8, payload width; legal range 5..9
- stop_bits, 1, 1 or 2
- tx_depth, 16, TX FIFO entries; power of 2, ≥2
- rx_depth, 16, RX FIFO entries; power of 2, ≥2

Ports:
- clk  in  1  system clock; one clock for the whole block
- reset  in  1  synchronous, active-high
- uart_rxd  in  1  serial input, asynchronous to clk
- uart_txd  out  1  serial output, idle high
- tx_data  in  data_bits  word to enqueue
- tx_wr  in  1  enqueue strobe, one word per cycle
- tx_busy  out  1  TX FIFO full
- tx_idle  out  1  TX FIFO empty and shifter idle
- rx_data  out  data_bits  head of the RX FIFO (show-ahead)
- rx_avail  out  1  RX FIFO non-empty
- rx_ack  in  1  pop strobe
- rx_error  out  1  one-cycle pulse: framing error (or parity error)
- rx_overflow  out  1  one-cycle pulse: received word dropped because the RX FIFO was full

## Operation
- Baud generator:
  - divisor = freq_hz/(baud*16), truncated; minimum 1.
  - Produces a one-cycle tick every divisor clocks.
  - The counter is free-running and shared by TX and RX.
- TX FIFO:
  - `tx_wr` with `tx_busy`=0 pushes `tx_data`.
  - `tx_wr` with `tx_busy`=1 is ignored; the word is lost and no flag is raised.
- TX FSM, states IDLE→START→DATA→[PARITY]→STOP→IDLE:
  - Each bit lasts 16 ticks.
  - DATA sends data_bits bits, LSB first.
  - STOP lasts stop_bits×16 ticks.
  - From STOP, the FSM goes directly to START if the FIFO is non-empty (back-to-back frames, no idle gap).
  - IDLE pops the FIFO on a tick when the FIFO is non-empty.
- RX path:
  - `uart_rxd` passes through a 2-flop synchroniser.
  - RX FSM, states IDLE→START→DATA→[PARITY]→STOP.
  - IDLE: a low sampled on a tick enters START.
  - START: samples at tick 8. High → false start, return to IDLE with no flag.
  - DATA: each bit is sampled 16 ticks after the previous sample.
  - STOP: only the first stop bit is sampled. Low → `rx_error` pulse and the word is discarded. High → the word is pushed.
  - After STOP the FSM returns to IDLE immediately (a mid-stop-bit resync point).
- RX FIFO:
  - Push while full → `rx_overflow` pulse; the word is dropped and the FIFO contents are unchanged.
  - Push and pop in the same cycle while full → both happen; no overflow.
  - `rx_ack` while empty is ignored.
- Pointers are log2(depth)+1 bits wide; full/empty is decided by comparing the MSBs. Wrap-around is modulo depth.

## Timing
- Reset values:
  - `uart_txd`=1
  - `tx_busy`=0
  - `tx_idle`=1
  - `rx_avail`=0
  - `rx_data`=0
  - `rx_error`=0
  - `rx_overflow`=0
- Reset effects:
  - Both FIFOs are emptied and both FSMs return to IDLE.
  - The baud counter is cleared.
- Reset mid-frame:
  - `uart_txd` is high the cycle after `reset` is sampled.
  - The partial RX word is discarded.
- `tx_busy` and `rx_avail` are registered and reflect a push or pop the following cycle.
- `rx_data` is valid whenever `rx_avail`=1. It updates to the next entry the cycle after an acknowledged pop.
- TX latency: `uart_txd` falls on the cycle after the first tick following the push (at most divisor+1 cycles after `tx_wr`).
- RX latency: `rx_avail` rises 1 cycle after the mid-stop-bit sample, i.e. 2 sync cycles + (1+data_bits)×16+8 ticks after the start edge, with ±1 tick of jitter.
- `tx_idle` rises the cycle after the final stop bit completes with an empty FIFO.

## Configuration
- `UART_BUFFERED_PARITY_EN` defined:
  - An even-parity bit is inserted after the data bits on TX (PARITY state, 16 ticks).
  - RX samples the parity bit. A mismatch pulses `rx_error` in the cycle the stop bit is sampled, and the word is discarded.
- `UART_BUFFERED_PARITY_EN` undefined:
  - The PARITY states and their logic are absent.
  - The frame is start + data + stop.

## Test plan
Common setup: freq_hz=50000000, baud=1562500 (divisor 2, 32 clk/bit), `uart_txd` looped back to `uart_rxd`.

1. Reset: hold `reset` for 4 cycles → `uart_txd`=1, `tx_idle`=1, `rx_avail`=0; after release, `uart_txd` stays 1 with no traffic.
2. Loopback: write 0x00, 0xFF, 0x80, 0x55 back-to-back → read 0x00, 0xFF, 0x80, 0x55 in order. No idle gap between frames; `rx_error` never pulses.
3. TX overfill, tx_depth=4: write 6 words in consecutive cycles → `tx_busy` is high after the 4th push (the word in the shifter popped is not counted until its tick). Exactly the words accepted while `tx_busy`=0 are received.
4. RX overflow, rx_depth=4, no ack: send 5 words → `rx_overflow` pulses once on the 5th. The FIFO holds words 1–4. Acking 4 times drains it and `rx_avail` falls.
5. Framing error: drive `uart_rxd` with 0xA5 and stop bit=0 → `rx_error` pulses once, `rx_avail` stays 0. The next valid 0x3C is received correctly.
6. Parity, macro on: inject 0x01 with wrong parity → `rx_error` pulses and the word is dropped. The same word with correct parity is received as 0x01.
